bus_timer_responder: RTL

- Memory-mapped timer peripheral on the shared processor bus: BUS_ADDR, BUS_DATA (tristate) and BUS_WE.
- It is the responder end of the bus and the interrupt-raising end of the RAISE/ACK handshake the Processor consumes.
- Prescales CLK to a millisecond tick, counts ticks, and raises a periodic interrupt that is held until the Processor acknowledges it.
- Sits beside RAM and the mouse peripheral. Its interrupt output is wired to BUS_INTERRUPTS_RAISE[1], and BUS_INTERRUPTS_ACK[1] is wired back to it.

---
 rtl/bus_timer_responder_pkg.sv | 24 ++
 rtl/bus_timer_responder_tick_prescaler.sv | 45 ++++
 rtl/bus_timer_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_timer_responder_pkg.sv
// ----------------------------------------------------------------------------
// bus_timer_pkg: shared register offsets, interrupt state type, reset values.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_timer_pkg;

  localparam logic [7:0] OFS_COUNT   = 8'd0;
  localparam logic [7:0] OFS_PERIOD  = 8'd1;
  localparam logic [7:0] OFS_CLEAR   = 8'd2;
  localparam logic [7:0] OFS_ENABLE  = 8'd3;
  localparam logic [7:0] OFS_OVERRUN = 8'd4;

  localparam logic ENABLE_RST = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/bus_timer_responder_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler: divides CLK by TICK_DIV, one-cycle tick at each wrap.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam int              CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear landing on the wrap edge suppresses that tick entirely.
  assign tick = wrap && !clear;

endmodule

`default_nettype wire

// File: rtl/bus_timer_responder.sv
// ----------------------------------------------------------------------------
// bus_timer_responder: bus-mapped millisecond timer with held RAISE/ACK irq.
// Optional OVERRUN register at +4 when TIMER_OVERRUN_CNT_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_timer_responder
  import bus_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         TICK_DIV   = 100000,
  parameter logic [7:0] PERIOD_RST = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

`ifdef TIMER_OVERRUN_CNT_EN
  localparam logic [7:0] LAST_OFS = OFS_OVERRUN;
`else
  localparam logic [7:0] LAST_OFS = OFS_ENABLE;
`endif

  logic [7:0]  offset;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic        wr_period;
  logic        wr_clear;
  logic        wr_enable;
  logic        tick;
  logic        fire;

  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  interval_q, interval_d;
  logic [7:0]  period_q,   period_d;
  logic        enable_q,   enable_d;
  irq_state_e  state_q,    state_d;
  logic [7:0]  rdata_q,    rdata_d;
  logic        oe_q,       oe_d;

  // The lower-bound compare stops wrapped offsets from aliasing into the block.
  assign offset    = BUS_ADDR - BASE_ADDR;
  assign hit       = (BUS_ADDR >= BASE_ADDR) && (offset <= LAST_OFS);
  assign wr_hit    = BUS_WE && hit;
  assign rd_hit    = !BUS_WE && hit;
  assign wr_period = wr_hit && (offset == OFS_PERIOD);
  assign wr_clear  = wr_hit && (offset == OFS_CLEAR);
  assign wr_enable = wr_hit && (offset == OFS_ENABLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (wr_clear),
    .tick  (tick)
  );

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    interval_d = interval_q;
    fire       = 1'b0;
    if (wr_clear) begin
      tick_cnt_d = '0;
      interval_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 32'd1;
      if (period_q == 8'd0) begin
        interval_d = '0;
      end else if (interval_q >= period_q - 8'd1) begin
        // >= rather than == so a shortened PERIOD fires on the next tick.
        fire       = 1'b1;
        interval_d = '0;
      end else begin
        interval_d = interval_q + 8'd1;
      end
    end
  end

  assign period_d = wr_period ? BUS_DATA    : period_q;
  assign enable_d = wr_enable ? BUS_DATA[0] : enable_q;

`ifdef TIMER_OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (wr_hit && (offset == OFS_OVERRUN)) begin
      overrun_d = '0;
    end else if (fire && enable_q && (state_q == PENDING) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end
`else
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fire && enable_q) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        // A fresh fire on the ACK edge keeps the request up.
        if (BUS_INTERRUPT_ACK && !(fire && enable_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    oe_d    = 1'b0;
    if (rd_hit) begin
      oe_d = 1'b1;
      case (offset)
        OFS_COUNT:   rdata_d = tick_cnt_q[7:0];
        OFS_PERIOD:  rdata_d = period_q;
        OFS_ENABLE:  rdata_d = {7'd0, enable_q};
`ifdef TIMER_OVERRUN_CNT_EN
        OFS_OVERRUN: rdata_d = overrun_q;
`endif
        default:     rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt_q <= '0;
      interval_q <= '0;
      period_q   <= PERIOD_RST;
      enable_q   <= ENABLE_RST;
      state_q    <= IDLE;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      interval_q <= interval_d;
      period_q   <= period_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
    end
  end

  assign BUS_INTERRUPT_RAISE = (state_q == PENDING);
  assign BUS_DATA            = (oe_q && !BUS_WE) ? rdata_q : 8'hzz;

endmodule

`default_nettype wire
